// File: rtl/pipe_stage_reg.sv
// Parametrised multi-slice pipeline register carrying a control and a data bundle with per-slice valid bits.
// Optional stall/bubble performance counters are built when PIPE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 101,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        occupancy
`ifdef PIPE_PERF_EN
    ,
    output logic [31:0]       stall_count,
    output logic [31:0]       bubble_count
`endif
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("pipe_stage_reg: STAGES must be in 1..4");
    end

    logic [STAGES-1:0] valid_next_vec;
    logic [2:0]        occupancy_next;
    logic [2:0]        occupancy_reg;

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_slice
        logic              valid_reg;
        logic [CTRL_W-1:0] ctrl_reg;
        logic [DATA_W-1:0] data_reg;
        logic              valid_next;
        logic [CTRL_W-1:0] ctrl_next;
        logic [DATA_W-1:0] data_next;
        logic              src_valid;
        logic [CTRL_W-1:0] src_ctrl;
        logic [DATA_W-1:0] src_data;

        if (gi == 0) begin : g_head
            // Gating ctrl at entry keeps ctrl==0 in every invalid slice.
            assign src_valid = in_valid;
            assign src_ctrl  = in_valid ? in_ctrl : '0;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = g_slice[gi-1].valid_reg;
            assign src_ctrl  = g_slice[gi-1].ctrl_reg;
            assign src_data  = g_slice[gi-1].data_reg;
        end

        always_comb begin
            valid_next = valid_reg;
            ctrl_next  = ctrl_reg;
            data_next  = data_reg;
            if (flush) begin
                valid_next = 1'b0;
                ctrl_next  = '0;
            end else if (!stall) begin
                valid_next = src_valid;
                ctrl_next  = src_ctrl;
                data_next  = src_data;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_reg <= 1'b0;
                ctrl_reg  <= '0;
                data_reg  <= '0;
            end else begin
                valid_reg <= valid_next;
                ctrl_reg  <= ctrl_next;
                data_reg  <= data_next;
            end
        end

        assign valid_next_vec[gi] = valid_next;
    end

    always_comb begin
        occupancy_next = 3'd0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy_next = occupancy_next + 3'(valid_next_vec[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy_reg <= 3'd0;
        end else begin
            occupancy_reg <= occupancy_next;
        end
    end

    assign out_valid = g_slice[STAGES-1].valid_reg;
    assign out_ctrl  = g_slice[STAGES-1].ctrl_reg;
    assign out_data  = g_slice[STAGES-1].data_reg;
    assign occupancy = occupancy_reg;

`ifdef PIPE_PERF_EN
    logic [31:0] stall_count_reg;
    logic [31:0] bubble_count_reg;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_reg  <= '0;
            bubble_count_reg <= '0;
        end else begin
            if (stall && !flush && stall_count_reg != 32'hFFFF_FFFF) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
            if (!stall && !flush && !in_valid && bubble_count_reg != 32'hFFFF_FFFF) begin
                bubble_count_reg <= bubble_count_reg + 32'd1;
            end
        end
    end

    assign stall_count  = stall_count_reg;
    assign bubble_count = bubble_count_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: drives STAGES=1,2,3 instances in parallel and checks them against
// per-instance scoreboard queues of in-flight slots.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic         v;
        logic [7:0]   c;
        logic [100:0] d;
    } slot_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [7:0]   in_ctrl;
    logic [100:0] in_data;
    logic         stall;
    logic         flush;

    logic         ov  [1:3];
    logic [7:0]   oc  [1:3];
    logic [100:0] od  [1:3];
    logic [2:0]   occ [1:3];
`ifdef PIPE_PERF_EN
    logic [31:0]  sc  [1:3];
    logic [31:0]  bc  [1:3];
    logic [31:0]  stall_exp  [1:3];
    logic [31:0]  bubble_exp [1:3];
`endif

    slot_t sb [1:3][$];
    int check_count = 0;
    int error_count = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(101), .STAGES(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush), .out_valid(ov[1]), .out_ctrl(oc[1]), .out_data(od[1]),
        .occupancy(occ[1])
`ifdef PIPE_PERF_EN
        , .stall_count(sc[1]), .bubble_count(bc[1])
`endif
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(101), .STAGES(2)) u2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush), .out_valid(ov[2]), .out_ctrl(oc[2]), .out_data(od[2]),
        .occupancy(occ[2])
`ifdef PIPE_PERF_EN
        , .stall_count(sc[2]), .bubble_count(bc[2])
`endif
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(101), .STAGES(3)) u3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush), .out_valid(ov[3]), .out_ctrl(oc[3]), .out_data(od[3]),
        .occupancy(occ[3])
`ifdef PIPE_PERF_EN
        , .stall_count(sc[3]), .bubble_count(bc[3])
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard update for one clock edge; front of each queue is the output slice.
    task automatic model_edge();
        slot_t tmp;
        slot_t slot;
        slot.v = in_valid;
        slot.c = in_valid ? in_ctrl : 8'h00;
        slot.d = in_data;
        for (int s = 1; s <= 3; s++) begin
            if (reset) begin
                sb[s].delete();
                for (int k = 0; k < s; k++) sb[s].push_back('0);
            end else if (flush) begin
                for (int k = 0; k < sb[s].size(); k++) begin
                    tmp = sb[s][k];
                    tmp.v = 1'b0;
                    tmp.c = 8'h00;
                    sb[s][k] = tmp;
                end
            end else if (!stall) begin
                tmp = sb[s].pop_front();
                sb[s].push_back(slot);
            end
`ifdef PIPE_PERF_EN
            if (reset) begin
                stall_exp[s]  = '0;
                bubble_exp[s] = '0;
            end else begin
                if (stall && !flush && stall_exp[s] != 32'hFFFF_FFFF) stall_exp[s] = stall_exp[s] + 1;
                if (!stall && !flush && !in_valid && bubble_exp[s] != 32'hFFFF_FFFF)
                    bubble_exp[s] = bubble_exp[s] + 1;
            end
`endif
        end
    endtask

    task automatic compare_all();
        slot_t exp_slot;
        int exp_occ;
        for (int s = 1; s <= 3; s++) begin
            exp_slot = sb[s][0];
            exp_occ = 0;
            for (int k = 0; k < sb[s].size(); k++) exp_occ += int'(sb[s][k].v);
            check($sformatf("s%0d out_valid", s), 128'(ov[s]), 128'(exp_slot.v));
            check($sformatf("s%0d out_ctrl", s), 128'(oc[s]), 128'(exp_slot.c));
            check($sformatf("s%0d out_data", s), 128'(od[s]), 128'(exp_slot.d));
            check($sformatf("s%0d occupancy", s), 128'(occ[s]), 128'(exp_occ));
`ifdef PIPE_PERF_EN
            check($sformatf("s%0d stall_count", s), 128'(sc[s]), 128'(stall_exp[s]));
            check($sformatf("s%0d bubble_count", s), 128'(bc[s]), 128'(bubble_exp[s]));
`endif
        end
    endtask

    task automatic step(input logic v, input logic [7:0] c, input logic [100:0] d,
                        input logic st, input logic fl, input logic rs);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
        stall    = st;
        flush    = fl;
        reset    = rs;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        $display("t=%0t rs=%0b fl=%0b st=%0b in_v=%0b in_c=%02h | s1 v=%0b c=%02h occ=%0d | s2 v=%0b c=%02h occ=%0d | s3 v=%0b c=%02h occ=%0d",
                 $time, rs, fl, st, v, c, ov[1], oc[1], occ[1], ov[2], oc[2], occ[2], ov[3], oc[3], occ[3]);
    endtask

    logic         r_v, r_st, r_fl, r_rs;
    logic [7:0]   r_c;
    logic [100:0] r_d;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; stall = 1'b0; flush = 1'b0;
`ifdef PIPE_PERF_EN
        for (int s = 1; s <= 3; s++) begin stall_exp[s] = '0; bubble_exp[s] = '0; end
`endif
        step(0, 8'h00, '0, 0, 0, 1);
        step(0, 8'h00, '0, 0, 0, 1);

        // Single transaction, then drain
        step(1, 8'h81, 101'h0ABC, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, '0, 0, 0, 0);

        // Back-to-back D1..D3, two-cycle stall with D4 held at the input, resume
        step(1, 8'h11, 101'h1_0000_0001, 0, 0, 0);
        step(1, 8'h22, 101'h1_0000_0002, 0, 0, 0);
        step(1, 8'h33, 101'h1_0000_0003, 0, 0, 0);
        step(1, 8'h44, 101'h1_0000_0004, 1, 0, 0);
        step(1, 8'h44, 101'h1_0000_0004, 1, 0, 0);
        step(1, 8'h44, 101'h1_0000_0004, 0, 0, 0);
        // Invalid slot carrying nonzero ctrl must exit as a clean bubble
        step(0, 8'hFF, 101'h5_5555, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, '0, 0, 0, 0);

        // Fill with ctrl FF, then flush together with stall
        for (int i = 0; i < 3; i++) step(1, 8'hFF, 101'(32'hDEAD_0000 + i), 0, 0, 0);
        step(1, 8'hFF, 101'h7777, 1, 1, 0);
        step(0, 8'h00, '0, 0, 0, 0);

        // Counter scenario after a clean reset: 5 stalls, 3 bubble shifts
        step(0, 8'h00, '0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 8'h00, '0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, '0, 0, 0, 0);

        // Mid-stream reset
        step(1, 8'h5A, 101'h9999, 0, 0, 0);
        step(1, 8'hA5, 101'h8888, 0, 0, 1);

        // Random traffic; input held stable while stalled
        r_v = 0; r_c = '0; r_d = '0;
        for (int i = 0; i < 300; i++) begin
            r_rs = ($urandom_range(0, 49) == 0);
            r_fl = ($urandom_range(0, 11) == 0);
            r_st = ($urandom_range(0, 3) == 0);
            if (!stall || flush || reset) begin
                r_v = 1'($urandom_range(0, 1));
                r_c = 8'($urandom);
                r_d = {5'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            end
            step(r_v, r_c, r_d, r_st, r_fl, r_rs);
        end

`ifdef PIPE_PERF_EN
        // Saturation of stall_count on the 3-slice instance
        force u3.stall_count_reg = 32'hFFFF_FFFF;
        #1;
        release u3.stall_count_reg;
        stall_exp[3] = 32'hFFFF_FFFF;
        step(in_valid, in_ctrl, in_data, 1, 0, 0);
        step(in_valid, in_ctrl, in_data, 1, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
